// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared types and helpers for the packet stream demultiplexer
package demux_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1,
    DROP  = 2'd2
  } state_e;

  // Smallest select width able to address n output ports.
  function automatic int min_sel_w(input int n);
    int w;
    w = 1;
    for (int i = 0; i < 31; i++) begin
      if ((1 << w) < n) w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/demux_out_slot.sv
// rtl/demux_out_slot.sv - one-entry registered output slot for a single demux port
module demux_out_slot #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              m_ready,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              free
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;

  always_comb begin
    free    = !valid_q || m_ready;
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    // A load in the same cycle as a pop keeps the slot full.
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      last_d  = load_last;
    end else if (m_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign m_valid = valid_q;
  assign m_data  = data_q;
  assign m_last  = last_q;

endmodule

// File: rtl/stream_demux_1_3.sv
// rtl/stream_demux_1_3.sv - packet-aware 1-to-N stream demux with invalid-select drop
module stream_demux_1_3
  import demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 3,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_W-1:0]       s_data,
  input  logic                    s_last,
  input  logic [SEL_W-1:0]        s_sel,
  output logic [N_OUT-1:0]        m_valid,
  input  logic [N_OUT-1:0]        m_ready,
  output logic [N_OUT*DATA_W-1:0] m_data,
  output logic [N_OUT-1:0]        m_last,
  output logic                    drop_pulse,
  output logic                    busy
);

  if (SEL_W < min_sel_w(N_OUT) || N_OUT < 2 || N_OUT > 8) begin : g_param_err
    $error("stream_demux_1_3: bad N_OUT/SEL_W combination");
  end

  localparam logic [SEL_W:0] N_OUT_X = (SEL_W + 1)'(N_OUT);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] route_q, route_d;
  logic             drop_q, drop_d;
  logic             busy_q, busy_d;

  logic [N_OUT-1:0]      slot_free;
  logic [N_OUT-1:0]      load_vec;
  logic [2**SEL_W-1:0]   free_ext;
  logic [SEL_W-1:0]      dest;
  logic                  dest_ok;
  logic                  sel_ok;
  logic                  accept;

  // Destination and readiness; an undeliverable beat is always accepted so it can be dropped.
  always_comb begin
    sel_ok   = {1'b0, s_sel} < N_OUT_X;
    free_ext = '0;
    free_ext[N_OUT-1:0] = slot_free;
    dest     = s_sel;
    dest_ok  = sel_ok;
    case (state_q)
      IDLE: begin
        dest    = s_sel;
        dest_ok = sel_ok;
      end
      ROUTE: begin
        dest    = route_q;
        dest_ok = 1'b1;
      end
      default: dest_ok = 1'b0;
    endcase
    s_ready = dest_ok ? free_ext[dest] : 1'b1;
    accept  = s_valid && s_ready;
    for (int k = 0; k < N_OUT; k++) begin
      load_vec[k] = accept && dest_ok && (dest == SEL_W'(k));
    end
  end

  always_comb begin
    state_d = state_q;
    route_d = route_q;
    drop_d  = 1'b0;
    if (accept) begin
      case (state_q)
        IDLE: begin
          if (sel_ok) begin
            if (!s_last) begin
              state_d = ROUTE;
              route_d = s_sel;
            end
          end else begin
            drop_d = 1'b1;
            if (!s_last) state_d = DROP;
          end
        end
        ROUTE, DROP: begin
          if (s_last) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      route_q <= '0;
      drop_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
      drop_q  <= drop_d;
      busy_q  <= busy_d;
    end
  end

  assign drop_pulse = drop_q;
  assign busy       = busy_q;

  for (genvar k = 0; k < N_OUT; k++) begin : g_slot
    demux_out_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (load_vec[k]),
      .load_data (s_data),
      .load_last (s_last),
      .m_ready   (m_ready[k]),
      .m_valid   (m_valid[k]),
      .m_data    (m_data[k*DATA_W +: DATA_W]),
      .m_last    (m_last[k]),
      .free      (slot_free[k])
    );
  end

endmodule

// File: tb/tb_stream_demux_1_3.sv
// tb/tb_stream_demux_1_3.sv - randomized and directed self-checking bench for stream_demux_1_3
module tb_stream_demux_1_3;

  localparam int DATA_W = 8;
  localparam int N_OUT  = 3;
  localparam int SEL_W  = 2;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    s_valid = 1'b0;
  logic                    s_ready;
  logic [DATA_W-1:0]       s_data = '0;
  logic                    s_last = 1'b0;
  logic [SEL_W-1:0]        s_sel = '0;
  logic [N_OUT-1:0]        m_valid;
  logic [N_OUT-1:0]        m_ready = '0;
  logic [N_OUT*DATA_W-1:0] m_data;
  logic [N_OUT-1:0]        m_last;
  logic                    drop_pulse;
  logic                    busy;

  stream_demux_1_3 #(.DATA_W(DATA_W), .N_OUT(N_OUT), .SEL_W(SEL_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .s_sel      (s_sel),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .drop_pulse (drop_pulse),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: a packet is either open to a port (pkt_dest>=0), open and discarded (-1), or closed.
  bit        in_pkt;
  int        pkt_dest;
  bit        ev [N_OUT];
  bit [7:0]  ed [N_OUT];
  bit        el [N_OUT];
  bit        edrop;
  bit        ebusy;
  int        delivered [N_OUT];

  function automatic void model_reset();
    in_pkt = 0;
    pkt_dest = -1;
    edrop = 0;
    ebusy = 0;
    for (int k = 0; k < N_OUT; k++) ev[k] = 0;
  endfunction

  task automatic step(input logic v, input logic [1:0] sel, input logic [7:0] d,
                      input logic l, input logic [2:0] mr);
    int  tgt;
    bit  rdy;
    bit  acc;
    @(negedge clk);
    s_valid = v; s_sel = sel; s_data = d; s_last = l; m_ready = mr;
    #1;
    tgt = in_pkt ? pkt_dest : int'(sel);
    rdy = (tgt < 0 || tgt >= N_OUT) ? 1'b1 : (!ev[tgt] || mr[tgt]);
    check("s_ready", 32'(s_ready), 32'(rdy));
    check("drop_pulse", 32'(drop_pulse), 32'(edrop));
    check("busy", 32'(busy), 32'(ebusy));
    for (int k = 0; k < N_OUT; k++) begin
      check($sformatf("m_valid[%0d]", k), 32'(m_valid[k]), 32'(ev[k]));
      if (ev[k]) begin
        check($sformatf("m_data[%0d]", k), 32'(m_data[k*DATA_W +: DATA_W]), 32'(ed[k]));
        check($sformatf("m_last[%0d]", k), 32'(m_last[k]), 32'(el[k]));
        if (mr[k]) delivered[k]++;
      end
    end
    acc = v && rdy;
    for (int k = 0; k < N_OUT; k++) if (ev[k] && mr[k]) ev[k] = 0;
    edrop = 0;
    if (acc) begin
      if (!in_pkt) begin
        tgt = (int'(sel) < N_OUT) ? int'(sel) : -1;
        if (tgt < 0) edrop = 1;
        if (!l) begin
          in_pkt = 1;
          pkt_dest = tgt;
        end
      end else if (l) begin
        in_pkt = 0;
      end
      if (tgt >= 0) begin
        ev[tgt] = 1; ed[tgt] = d; el[tgt] = l;
      end
    end
    ebusy = in_pkt;
    @(posedge clk);
  endtask

  int drops_seen;

  initial begin
    model_reset();
    for (int k = 0; k < N_OUT; k++) delivered[k] = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_m_valid", 32'(m_valid), 32'h0);
    check("rst_m_data", 32'(m_data), 32'h0);
    check("rst_m_last", 32'(m_last), 32'h0);
    check("rst_drop", 32'(drop_pulse), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Single-beat routing to port 2
    step(1, 2, 8'hA5, 1, 3'b111);
    #1;
    check("single_valid", 32'(m_valid), 32'b100);
    check("single_data", 32'(m_data[23:16]), 32'hA5);
    check("single_last", 32'(m_last[2]), 32'h1);
    check("single_busy", 32'(busy), 32'h0);

    // Multi-beat packet to port 1; later beats carry a misleading select
    for (int i = 0; i < 4; i++) begin
      step(1, (i == 0) ? 2'd1 : 2'd0, 8'h10 + 8'(i), (i == 3), 3'b111);
      #1;
      check("multi_port1_only", 32'(m_valid), 32'b010);
      check("multi_data", 32'(m_data[15:8]), 32'h10 + i);
      check("multi_busy", 32'(busy), (i < 3) ? 32'h1 : 32'h0);
    end
    step(0, 0, 0, 0, 3'b111);

    // Backpressure on port 0
    step(1, 0, 8'h21, 0, 3'b110);
    step(1, 0, 8'h22, 0, 3'b110);
    step(1, 0, 8'h22, 0, 3'b110);
    #1;
    check("bp_hold", 32'(m_data[7:0]), 32'h21);
    check("bp_stall", 32'(s_ready), 32'h0);
    step(1, 0, 8'h22, 0, 3'b111);
    step(1, 0, 8'h23, 0, 3'b111);
    step(1, 0, 8'h24, 1, 3'b111);
    step(0, 0, 0, 0, 3'b111);

    // Invalid select: 3-beat packet dropped
    drops_seen = 0;
    for (int i = 0; i < 3; i++) begin
      step(1, 3, 8'h30 + 8'(i), (i == 2), 3'b111);
      drops_seen += int'(drop_pulse);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 3'b111);
      drops_seen += int'(drop_pulse);
    end
    check("drop_count", 32'(drops_seen), 32'h1);

    // Independent ports: port 0 stalled while port 2 streams
    step(1, 0, 8'h55, 1, 3'b000);
    for (int i = 0; i < 3; i++) step(1, 2, 8'h60 + 8'(i), (i == 2), 3'b100);
    step(0, 0, 0, 0, 3'b100);
    #1;
    check("indep_hold_valid", 32'(m_valid[0]), 32'h1);
    check("indep_hold_data", 32'(m_data[7:0]), 32'h55);
    step(0, 0, 0, 0, 3'b111);

    // Async reset in the middle of a port-1 packet
    step(1, 1, 8'h70, 0, 3'b000);
    step(1, 1, 8'h71, 0, 3'b010);
    @(negedge clk);
    s_valid = 1; s_sel = 1; s_data = 8'h72; s_last = 0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_m_valid", 32'(m_valid), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    model_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    step(1, 0, 8'h80, 1, 3'b111);
    #1;
    check("arst_head_port0", 32'(m_valid), 32'b001);
    check("arst_head_data", 32'(m_data[7:0]), 32'h80);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)), 8'($urandom),
           ($urandom_range(0, 9) < 3), 3'($urandom));
    end
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 3'b111);
    check("drained", 32'(m_valid), 32'h0);
    for (int k = 0; k < N_OUT; k++) check($sformatf("traffic_port%0d", k), 32'(delivered[k] > 20), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_demux_1_3.md
Name: stream_demux_1_3

Overview:
- Packet-aware 1-to-N stream demultiplexer: the routing counterpart to the team's select-tree muxes.
- Accepts one valid/ready input stream whose head beat carries a destination select. Steers the whole packet (through s_last) to one of N_OUT registered output ports.
- Packets addressed to a non-existent port are consumed and dropped, with a flag raised.
- Sits between a single producer and up to N_OUT consumers in the datapath fabric.

Parameters:
- DATA_W, 8, data beat width.
- N_OUT, 3, number of output ports (2..8).
- SEL_W, 2, select width; must satisfy 2**SEL_W >= N_OUT. Select values >= N_OUT are invalid.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat ready (combinational).
- s_data  in  DATA_W  input beat data.
- s_last  in  1  final beat of packet.
- s_sel  in  SEL_W  destination port; sampled only on a packet head beat.
- m_valid  out  N_OUT  per-port output valid.
- m_ready  in  N_OUT  per-port output ready.
- m_data  out  N_OUT*DATA_W  per-port data; port k occupies bits [k*DATA_W +: DATA_W].
- m_last  out  N_OUT  per-port last.
- drop_pulse  out  1  one-cycle pulse when a packet head with invalid s_sel is accepted.
- busy  out  1  high while in the ROUTE or DROP state.

Behaviour:
- Reset (async, rst=1): state=IDLE, route_q=0, all m_valid/m_data/m_last=0, drop_pulse=0, busy=0.
- Reset mid-packet: all buffered and in-flight beats are discarded. The first beat accepted after rst deasserts is treated as a packet head.
- Handshake: a beat transfers when s_valid && s_ready. Output port k transfers when m_valid[k] && m_ready[k]. Once m_valid is asserted, data is held stable until the transfer.
- Output slot, per port, one entry deep:
  - Free when !m_valid[k] || m_ready[k].
  - A beat accepted for port k loads data/last and sets m_valid[k] at the next edge.
  - Latency from input handshake to m_valid is 1 cycle.
  - If a pop and a load occur in the same cycle, the load wins and m_valid stays 1. Throughput is 1 beat/cycle per port.
  - A pop with no load clears m_valid[k].
  - m_data/m_last retain their last value when not valid.
- Effective destination dest:
  - IDLE: s_sel.
  - ROUTE: route_q.
  - DROP: none.
- s_ready:
  - IDLE: 1 if s_sel >= N_OUT, else slot[s_sel] free.
  - ROUTE: slot[route_q] free.
  - DROP: 1.
  - s_ready never depends on s_valid.
- FSM, evaluated on an accepted beat only (no transitions otherwise):
  - IDLE, valid sel, s_last=1: single-beat packet, stay IDLE.
  - IDLE, valid sel, s_last=0: route_q<=s_sel, go to ROUTE.
  - IDLE, invalid sel: beat discarded, drop_pulse=1 next cycle. s_last=1: stay IDLE. s_last=0: go to DROP.
  - ROUTE: beat goes to route_q; s_sel is ignored. s_last=1: go to IDLE.
  - DROP: beat discarded. s_last=1: go to IDLE.
- Non-target ports are unaffected by routing and continue draining independently. Back-to-back packets to different ports incur no bubble.
- drop_pulse is high exactly one cycle per dropped packet, never per beat.
- busy = (state != IDLE).

Decomposition:
- Package demux_pkg holds:
  - state enum {IDLE, ROUTE, DROP};
  - a function returning the minimum SEL_W for a given N_OUT, used for a parameter sanity check.
- Sub-module demux_out_slot is the one-entry output register with the load/pop rules above. It is instantiated N_OUT times via generate.
- The top level holds the FSM, route_q, s_ready logic and drop logic.

Test Plan:
- Single-beat routing: s_sel=2, s_data=8'hA5, s_last=1, m_ready=3'b111 -> m_valid=3'b100 one cycle later, m_data[23:16]=8'hA5, m_last[2]=1, busy stays 0.
- Multi-beat packet:
  - Stimulus: 4 beats 8'h10..8'h13, head s_sel=1; later beats drive s_sel=0.
  - Required: all 4 beats appear only on port 1, in order, with m_last[1] on 8'h13 only; busy=1 from after beat 0 through the cycle of beat 3.
- Backpressure: route to port 0 with m_ready[0]=0 -> first beat held in the slot, s_ready=0 until m_ready[0]=1, then 1 beat/cycle with no loss or duplication.
- Invalid select:
  - Stimulus: 3-beat packet with head s_sel=3 (N_OUT=3).
  - Required: s_ready=1 on every beat, no m_valid asserted, drop_pulse high for exactly 1 cycle, FSM returns to IDLE after the last beat.
- Independent ports: port 0 stalled (m_ready[0]=0) holding 8'h55, then a packet sent to port 2 -> port 2 receives it at full rate while m_valid[0] and m_data[7:0]=8'h55 remain held.
- Async reset mid-packet: assert rst between clock edges during beat 2 of a port-1 packet -> m_valid=0 immediately; after release, the next beat with s_sel=0 routes to port 0.
